seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Parametrised, time-multiplexed driver for NUM_DIGITS seven-segment digits; successor to the single-digit 0-8 decoder.
- Adds full hex decode (0-F), per-digit decimal point and blanking, and a digit-scan counter with inter-digit dead time.
- Adds tear-free double-buffered loading, committed only at frame boundaries.
- Sits between the display-value producers and the board's shared segment bus plus per-digit anode enables.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits; legal range 1..16.
- SCAN_DIV, 1000, clk cycles each digit is selected, including dead time; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; 0 blanks the display and freezes the counters.
- load  input  1  capture strobe for digits/dots/blank.
- digits  input  4*NUM_DIGITS  hex value per digit; digit i is bits [4i+3:4i].
- dots  input  NUM_DIGITS  1 = decimal point lit for digit i.
- blank  input  NUM_DIGITS  1 = digit i fully dark.
- seg_out  output  8  active-low {a,b,c,d,e,f,g,dp}; a = bit7, dp = bit0.
- an  output  NUM_DIGITS  active-low digit select; one-hot-low when lit.
- frame_done  output  1  one-cycle pulse when the scan index wraps to 0.

Behaviour:
- Reset (async, immediate):
  - div_cnt = 0, idx = 0.
  - Active and pending digits = 0, dots = 0, blank = all 1s, pending_valid = 0.
  - seg_out = 8'hFF, an = all 1s, frame_done = 0.
- Divider: div_cnt counts 0..SCAN_DIV-1 while en = 1, then wraps to 0.
  - On wrap, idx increments; at NUM_DIGITS-1 it wraps to 0 and frame_done = 1 on that same edge.
- All outputs are registered; latency is 1 cycle from counter state.
- Dead time: in any cycle where div_cnt == 0, outputs are an = all 1s and seg_out = 8'hFF. This suppresses ghosting on digit change.
- When div_cnt != 0:
  - an = ~(1 << idx).
  - seg_out = 8'hFF if active blank[idx] = 1.
  - Otherwise seg_out = {decode(active digit[idx]), ~active dot[idx]}.
- Decode, a..g active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- en = 0:
  - Next edge: an = all 1s, seg_out = 8'hFF, frame_done = 0.
  - div_cnt and idx hold.
  - load and commit still operate.
- load (sampled every edge, independent of en):
  - Captures digits/dots/blank into the pending buffer and sets pending_valid.
  - Repeated loads before a boundary: last one wins.
- Commit: on the edge where idx wraps to 0, if pending_valid, copy pending to active and clear pending_valid.
  - If load coincides with that edge, the load inputs go straight to active and pending_valid clears.
  - When en = 0 no boundary occurs; data stays pending until scanning resumes.
- NUM_DIGITS = 1: idx stays 0 and frame_done pulses every SCAN_DIV cycles.
- Reset mid-frame aborts scan and discards pending data; the display is dark until the next load is committed.

Test Plan:
- NUM_DIGITS = 4, SCAN_DIV = 4, reset released, en = 1, no load:
  - seg_out stays 8'hFF (all blank).
  - an cycles 1110, 1101, 1011, 0111, with an = 1111 in each dead cycle.
  - frame_done pulses every 16 cycles.
- Load digits = 16'h3A0F, dots = 4'b0010, blank = 0, then wait one frame boundary. Required seg_out in non-dead cycles:
  - Digit 0: 0111000_1 (F)
  - Digit 1: 0000001_0 (0, with dp)
  - Digit 2: 0001000_1 (A)
  - Digit 3: 0000110_1 (3)
- Load mid-frame: the old value is shown until idx wraps to 0, then the new value appears. Two loads before a boundary: only the second is displayed.
- Load asserted on the exact wrap edge: the new value is shown in digit 0's first non-dead cycle. An earlier pending value is discarded.
- en deasserted for 10 cycles mid-digit:
  - Outputs are dark (8'hFF / 1111) and div_cnt/idx are frozen.
  - On re-enable, scanning resumes at the same idx/div_cnt.
- Async rst pulsed between clock edges mid-frame: outputs are immediately 8'hFF / 1111, idx = 0, the pending load is lost, and frame_done = 0.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bus between display-value producers and the seg_scan digit multiplexer.
// Carries the load-side inputs and the segment/anode/frame outputs as one bundle.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8
);
    // load is a single-cycle capture strobe with no back-pressure: every edge
    // that sees load = 1 captures digits/dots/blank. There is no ready signal.
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dots;
    logic [NUM_DIGITS-1:0]     blank;
    logic [7:0]                seg_out;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;

    modport master (
        output en, load, digits, dots, blank,
        input  seg_out, an, frame_done
    );

    modport slave (
        input  en, load, digits, dots, blank,
        output seg_out, an, frame_done
    );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment driver: hex decode, per-digit dp/blank, dead time
// between digits, and double-buffered display data committed only at frame wrap.
module seg_scan #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_act_digits;
    logic [NUM_DIGITS-1:0]   r_act_dots;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [4*NUM_DIGITS-1:0] r_pend_digits;
    logic [NUM_DIGITS-1:0]   r_pend_dots;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic                    r_pend_valid;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_div_last;
    logic                    w_wrap;
    logic [3:0]              w_nib;
    logic                    w_dot;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an;
    logic [6:0]              w_seg7;

    assign w_div_last = (r_div_cnt == DIV_LAST);
    assign w_wrap     = bus.en && w_div_last && (r_idx == IDX_LAST);
    assign w_nib      = 4'(r_act_digits >> {r_idx, 2'b00});
    assign w_dot      = 1'(r_act_dots >> r_idx);
    assign w_blank    = 1'(r_act_blank >> r_idx);
    assign w_an       = ~(NUM_DIGITS'(1) << r_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (bus.en) begin
            if (w_div_last) begin
                r_div_cnt <= '0;
                r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    // A load on the wrap edge bypasses the pending buffer and supersedes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_digits  <= '0;
            r_act_dots    <= '0;
            r_act_blank   <= '1;
            r_pend_digits <= '0;
            r_pend_dots   <= '0;
            r_pend_blank  <= '1;
            r_pend_valid  <= 1'b0;
        end else if (w_wrap && (bus.load || r_pend_valid)) begin
            r_act_digits <= bus.load ? bus.digits : r_pend_digits;
            r_act_dots   <= bus.load ? bus.dots   : r_pend_dots;
            r_act_blank  <= bus.load ? bus.blank  : r_pend_blank;
            r_pend_valid <= 1'b0;
        end else if (bus.load) begin
            r_pend_digits <= bus.digits;
            r_pend_dots   <= bus.dots;
            r_pend_blank  <= bus.blank;
            r_pend_valid  <= 1'b1;
        end
    end

    always_comb begin
        w_seg7 = 7'b1111111;
        case (w_nib)
            4'h0: w_seg7 = 7'b0000001;
            4'h1: w_seg7 = 7'b1001111;
            4'h2: w_seg7 = 7'b0010010;
            4'h3: w_seg7 = 7'b0000110;
            4'h4: w_seg7 = 7'b1001100;
            4'h5: w_seg7 = 7'b0100100;
            4'h6: w_seg7 = 7'b0100000;
            4'h7: w_seg7 = 7'b0001111;
            4'h8: w_seg7 = 7'b0000000;
            4'h9: w_seg7 = 7'b0000100;
            4'hA: w_seg7 = 7'b0001000;
            4'hB: w_seg7 = 7'b1100000;
            4'hC: w_seg7 = 7'b0110001;
            4'hD: w_seg7 = 7'b1000010;
            4'hE: w_seg7 = 7'b0110000;
            4'hF: w_seg7 = 7'b0111000;
            default: w_seg7 = 7'b1111111;
        endcase
    end

    // div_cnt == 0 is the dead slot that hides the anode/segment switch-over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg        <= 8'hFF;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (!bus.en || (r_div_cnt == '0)) begin
                r_seg <= 8'hFF;
                r_an  <= '1;
            end else begin
                r_an  <= w_an;
                r_seg <= w_blank ? 8'hFF : {w_seg7, ~w_dot};
            end
        end
    end

    assign bus.seg_out    = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan (4 digits, 4-cycle slots): a position-based display model
// feeds an expected queue that a free-running monitor compares every cycle.
module tb_seg_scan;
  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int FRAME = ND * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model: display position = enabled cycles since reset, modulo one frame.
  int          pos;
  logic [15:0] m_act_d, m_pend_d;
  logic [3:0]  m_act_dt, m_act_bl, m_pend_dt, m_pend_bl;
  logic        m_pend_v;

  logic [12:0] exp_q [$];

  task automatic model_reset();
    pos = 0;
    m_act_d = '0;  m_act_dt = '0;  m_act_bl = '1;
    m_pend_d = '0; m_pend_dt = '0; m_pend_bl = '1;
    m_pend_v = 1'b0;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle at the negedge and queue what the next posedge must produce.
  task automatic step(input logic e, input logic ld, input logic [15:0] d,
                      input logic [3:0] dt, input logic [3:0] bl);
    logic [7:0] seg_e;
    logic [3:0] an_e;
    logic       fd_e;
    int         ix;
    bus.en = e; bus.load = ld; bus.digits = d; bus.dots = dt; bus.blank = bl;
    ix    = pos / SD;
    seg_e = 8'hFF;
    an_e  = 4'hF;
    if (e && (pos % SD) != 0) begin
      an_e[ix] = 1'b0;
      if (!m_act_bl[ix]) seg_e = {seg_tab[m_act_d[4*ix +: 4]], ~m_act_dt[ix]};
    end
    fd_e = e && (pos == FRAME - 1);
    exp_q.push_back({seg_e, an_e, fd_e});
    if (e) pos = (pos + 1) % FRAME;
    if (fd_e && (ld || m_pend_v)) begin
      if (ld) begin
        m_act_d = d; m_act_dt = dt; m_act_bl = bl;
      end else begin
        m_act_d = m_pend_d; m_act_dt = m_pend_dt; m_act_bl = m_pend_bl;
      end
      m_pend_v = 1'b0;
    end else if (ld) begin
      m_pend_d = d; m_pend_dt = dt; m_pend_bl = bl;
      m_pend_v = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  // After the next frame_done, find the slot of digit dig and check its segments.
  task automatic scan_check(input int dig, input logic [7:0] exp_seg);
    bit seen = 1'b0;
    bit done = 1'b0;
    logic [3:0] an_t;
    an_t = 4'hF;
    an_t[dig] = 1'b0;
    for (int i = 0; i < 3 * FRAME && !done; i++) begin
      idle(1);
      if (bus.frame_done) seen = 1'b1;
      else if (seen && bus.an == an_t) begin
        chk8($sformatf("digit%0d_seg", dig), bus.seg_out, exp_seg);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL scan_check_timeout digit=%0d", dig);
    end
  endtask

  // Async reset asserted between edges; outputs must go dark immediately.
  task automatic rst_pulse();
    bus.load = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk8("rst_async_seg", bus.seg_out, 8'hFF);
    chk8("rst_async_an", {4'h0, bus.an}, 8'h0F);
    chk8("rst_async_fd", {7'h0, bus.frame_done}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    logic [12:0] exp, act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {bus.seg_out, bus.an, bus.frame_done};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL scoreboard t=%0t got seg=%h an=%b fd=%b exp seg=%h an=%b fd=%b",
                   $time, act[12:5], act[4:1], act[0], exp[12:5], exp[4:1], exp[0]);
        end
      end
    end
  end

  initial begin : driver
    bus.en = 1'b0; bus.load = 1'b0; bus.digits = '0; bus.dots = '0; bus.blank = '0;
    model_reset();
    #12;
    chk8("reset_seg", bus.seg_out, 8'hFF);
    chk8("reset_an", {4'h0, bus.an}, 8'h0F);
    chk8("reset_fd", {7'h0, bus.frame_done}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Blank scan after reset, three frames.
    idle(3 * FRAME);

    // Example pattern.
    step(1'b1, 1'b1, 16'h3A0F, 4'b0010, 4'b0000);
    scan_check(0, 8'h71);
    scan_check(1, 8'h02);
    scan_check(2, 8'h11);
    scan_check(3, 8'h0D);

    // Two loads before one boundary: the second wins.
    idle(3);
    step(1'b1, 1'b1, 16'h1234, 4'b0000, 4'b0000);
    idle(2);
    step(1'b1, 1'b1, 16'hEB56, 4'b1000, 4'b0100);
    scan_check(0, 8'h41);
    scan_check(2, 8'hFF);
    scan_check(3, 8'h60);

    // Pending load then another load exactly on the wrap edge.
    idle(5);
    step(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'h0);
    while (pos != FRAME - 1) idle(1);
    step(1'b1, 1'b1, 16'h0002, 4'h0, 4'h0);
    idle(2);
    scan_check(0, 8'h25);

    // Enable dropped for 10 cycles mid-digit.
    while (pos % SD != 2) idle(1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(2 * FRAME);

    // Pending load lost to a mid-frame reset.
    idle(5);
    step(1'b1, 1'b1, 16'h9999, 4'h0, 4'h0);
    idle(2);
    rst_pulse();
    idle(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic       e, ld;
      logic [3:0] bl;
      e  = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 15) == 0);
      bl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(e, ld, 16'($urandom), 4'($urandom_range(0, 15)), bl);
      if ($urandom_range(0, 249) == 0) rst_pulse();
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain left=%0d", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
